// File: rtl/fetch_pc_sequencer.sv
// IF1 fetch-address owner: FetchPC registered, one new PC per cycle on hit; controls combinational from state.
// Backpressure: I-cache miss -> Bubble/MISS, Queue_Full -> Stall/HOLD; optional FETCH_SEQ_PERF_EN adds perf counters.
module fetch_pc_sequencer #(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(64'h8000_0000),
  parameter int              FETCH_RATE   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Redirect_Valid,
  input  logic [XLEN-1:0] Redirect_PC,
  input  logic            Predict_Taken,
  input  logic [XLEN-1:0] Predict_Target,
  input  logic [XLEN-1:0] NextFetchAddr,
  input  logic            Icache_Hit,
  input  logic            Queue_Full,
  output logic            Icache_Req,
  output logic [XLEN-1:0] FetchPC,
  output logic            Stall,
  output logic            Flush,
  output logic            Bubble
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0]     Perf_MissCycles,
  output logic [31:0]     Perf_Redirects
`endif
);

  generate
    if (FETCH_RATE < 2 || RESET_VECTOR[1:0] != 2'b00) begin : g_bad_cfg
      $error("fetch_pc_sequencer: bad FETCH_RATE or misaligned RESET_VECTOR");
    end
  endgenerate

  typedef enum logic [1:0] {BOOT, RUN, MISS, HOLD} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic            unused_lsb;

  // Targets are halfword aligned; bit0 from either source is discarded.
  assign unused_lsb = ^{Redirect_PC[0], Predict_Target[0]};

  always_comb begin
    state_nxt  = state;
    pc_nxt     = FetchPC;
    Icache_Req = 1'b0;
    Stall      = 1'b0;
    Flush      = 1'b0;
    Bubble     = 1'b0;
    case (state)
      BOOT: begin
        Flush     = 1'b1;
        state_nxt = RUN;
      end
      RUN, MISS: begin
        Icache_Req = 1'b1;
        if (!Icache_Hit) begin
          Bubble    = 1'b1;
          state_nxt = MISS;
        end else if (Queue_Full) begin
          Stall     = 1'b1;
          state_nxt = HOLD;
        end else begin
          state_nxt = RUN;
          pc_nxt    = Predict_Taken ? {Predict_Target[XLEN-1:1], 1'b0} : NextFetchAddr;
        end
      end
      HOLD: begin
        Icache_Req = 1'b1;
        Stall      = 1'b1;
        // Leave without advancing: the held line is looked up again from RUN.
        if (!Queue_Full) state_nxt = RUN;
      end
      default: state_nxt = BOOT;
    endcase
    if (Redirect_Valid) begin
      Flush     = 1'b1;
      Stall     = 1'b0;
      Bubble    = 1'b0;
      state_nxt = RUN;
      pc_nxt    = {Redirect_PC[XLEN-1:1], 1'b0};
    end
    if (rst) begin
      Icache_Req = 1'b0;
      Stall      = 1'b0;
      Flush      = 1'b1;
      Bubble     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BOOT;
      FetchPC <= RESET_VECTOR;
    end else begin
      state   <= state_nxt;
      FetchPC <= pc_nxt;
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      Perf_MissCycles <= '0;
      Perf_Redirects  <= '0;
    end else begin
      if (state == MISS && Perf_MissCycles != 32'hFFFF_FFFF)
        Perf_MissCycles <= Perf_MissCycles + 32'd1;
      if (Redirect_Valid && Perf_Redirects != 32'hFFFF_FFFF)
        Perf_Redirects <= Perf_Redirects + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Scoreboarded bench for fetch_pc_sequencer: directed scenarios followed by a random run.
module tb_fetch_pc_sequencer;
  localparam logic [63:0] RV = 64'h8000_0000;
  localparam int MB = 0, MR = 1, MM = 2, MH = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Redirect_Valid = 1'b0;
  logic [63:0] Redirect_PC = '0;
  logic        Predict_Taken = 1'b0;
  logic [63:0] Predict_Target = '0;
  logic [63:0] NextFetchAddr = '0;
  logic        Icache_Hit = 1'b0;
  logic        Queue_Full = 1'b0;
  logic        Icache_Req;
  logic [63:0] FetchPC;
  logic        Stall, Flush, Bubble;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] Perf_MissCycles, Perf_Redirects;
`endif

  fetch_pc_sequencer dut (
    .clk(clk), .rst(rst),
    .Redirect_Valid(Redirect_Valid), .Redirect_PC(Redirect_PC),
    .Predict_Taken(Predict_Taken), .Predict_Target(Predict_Target),
    .NextFetchAddr(NextFetchAddr), .Icache_Hit(Icache_Hit), .Queue_Full(Queue_Full),
    .Icache_Req(Icache_Req), .FetchPC(FetchPC),
    .Stall(Stall), .Flush(Flush), .Bubble(Bubble)
`ifdef FETCH_SEQ_PERF_EN
    , .Perf_MissCycles(Perf_MissCycles), .Perf_Redirects(Perf_Redirects)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic        stall;
    logic        flush;
    logic        bubble;
    logic [63:0] pc;
    logic [31:0] miss;
    logic [31:0] red;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          m_st = MB;
  logic [63:0] m_pc = RV;
  logic [31:0] m_miss = '0;
  logic [31:0] m_red = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs, predict outputs and next state, compare once settled.
  task automatic step(input bit r, input bit rv, input logic [63:0] rpc, input bit pt,
                      input logic [63:0] ptgt, input bit hit, input bit qf);
    exp_t        e, g;
    int          nst;
    logic [63:0] npc;
    @(negedge clk);
    rst = r; Redirect_Valid = rv; Redirect_PC = rpc; Predict_Taken = pt;
    Predict_Target = ptgt; Icache_Hit = hit; Queue_Full = qf;
    NextFetchAddr = m_pc + 64'd16;
    e = '0; e.pc = m_pc; e.miss = m_miss; e.red = m_red;
    nst = m_st; npc = m_pc;
    if (r) begin
      e.flush = 1'b1; nst = MB; npc = RV;
    end else if (rv) begin
      e.flush = 1'b1; e.req = (m_st != MB); nst = MR; npc = {rpc[63:1], 1'b0};
    end else if (m_st == MB) begin
      e.flush = 1'b1; nst = MR;
    end else if (m_st == MH) begin
      e.req = 1'b1; e.stall = 1'b1;
      if (!qf) nst = MR;
    end else begin
      e.req = 1'b1;
      if (!hit) begin e.bubble = 1'b1; nst = MM; end
      else if (qf) begin e.stall = 1'b1; nst = MH; end
      else begin nst = MR; npc = pt ? {ptgt[63:1], 1'b0} : m_pc + 64'd16; end
    end
    exp_q.push_back(e);
    #1;
    g = exp_q.pop_front();
    check_eq("req", {63'd0, Icache_Req}, {63'd0, g.req});
    check_eq("stall", {63'd0, Stall}, {63'd0, g.stall});
    check_eq("flush", {63'd0, Flush}, {63'd0, g.flush});
    check_eq("bubble", {63'd0, Bubble}, {63'd0, g.bubble});
    check_eq("fetch_pc", FetchPC, g.pc);
`ifdef FETCH_SEQ_PERF_EN
    check_eq("perf_miss", {32'd0, Perf_MissCycles}, {32'd0, g.miss});
    check_eq("perf_redir", {32'd0, Perf_Redirects}, {32'd0, g.red});
`endif
    if (r) begin
      m_miss = '0; m_red = '0;
    end else begin
      if (m_st == MM && m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
      if (rv && m_red != 32'hFFFF_FFFF) m_red = m_red + 1;
    end
    m_st = nst; m_pc = npc;
  endtask

  task automatic hitc();
    step(0, 0, '0, 0, '0, 1, 0);
  endtask

  task automatic pc_after(input string tag, input logic [63:0] exp);
    @(posedge clk);
    #1;
    check_eq(tag, FetchPC, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step(1, 0, '0, 0, '0, 1, 0);
    step(1, 0, '0, 0, '0, 1, 0);
    // Boot cycle, then one new PC per hit cycle.
    hitc();
    hitc(); pc_after("t1_pc1", 64'h8000_0010);
    hitc(); pc_after("t1_pc2", 64'h8000_0020);
    hitc(); hitc();
    // Three miss cycles at 8000_0040.
    repeat (3) step(0, 0, '0, 0, '0, 0, 0);
    hitc(); pc_after("t2_pc", 64'h8000_0050);
`ifdef FETCH_SEQ_PERF_EN
    check_eq("t2_perf_miss", {32'd0, Perf_MissCycles}, 64'd3);
`endif
    step(0, 0, '0, 0, '0, 1, 1);
    step(0, 0, '0, 0, '0, 1, 1);
    step(0, 0, '0, 0, '0, 1, 0); pc_after("t3_held_pc", 64'h8000_0050);
    hitc(); pc_after("t3_adv_pc", 64'h8000_0060);
    // Redirect beats simultaneous prediction and backpressure.
    step(0, 1, 64'h8000_1003, 1, 64'h8000_2000, 1, 1); pc_after("t4_pc", 64'h8000_1002);
    hitc(); pc_after("t4_run_pc", 64'h8000_1012);
    step(0, 0, '0, 1, 64'h8000_2000, 1, 0); pc_after("t5_pred_pc", 64'h8000_2000);
    step(0, 0, '0, 0, '0, 0, 0);
    step(0, 0, '0, 0, '0, 0, 0);
    step(0, 1, 64'h8000_3000, 0, '0, 0, 0); pc_after("t5_redir_pc", 64'h8000_3000);
    hitc(); pc_after("t5_run_pc", 64'h8000_3010);
    // Reset while holding.
    step(0, 0, '0, 0, '0, 1, 1);
    step(1, 0, '0, 0, '0, 1, 1); pc_after("t6_pc", RV);
`ifdef FETCH_SEQ_PERF_EN
    check_eq("t6_perf_miss", {32'd0, Perf_MissCycles}, 64'd0);
    check_eq("t6_perf_redir", {32'd0, Perf_Redirects}, 64'd0);
`endif
    hitc();
    // Wrap of the sequential address at 2^64.
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFF1, 0, '0, 1, 0); pc_after("wrap_pre", 64'hFFFF_FFFF_FFFF_FFF0);
    hitc(); pc_after("wrap_pc", 64'h0);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) < 3), ($urandom_range(99) < 10),
           {$urandom, $urandom}, ($urandom_range(99) < 25), {$urandom, $urandom},
           ($urandom_range(99) < 75), ($urandom_range(99) < 20));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
